// File: rtl/a23_gc_pkg.sv
// Shared constants and types for the a23 garbled-circuit memory subsystem.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package a23_gc_pkg;

    // Region prefixes decoded from address bits [31:24]
    localparam logic [7:0] PFX_CODE    = 8'h00;
    localparam logic [7:0] PFX_IN0     = 8'h01;   // legacy alias for input channel 0
    localparam logic [7:0] PFX_IN1     = 8'h02;   // legacy alias for input channel 1
    localparam logic [7:0] PFX_OUT     = 8'h03;
    localparam logic [7:0] PFX_STACK   = 8'h04;
    localparam logic [7:0] PFX_CTRL    = 8'h05;
    localparam logic [7:0] PFX_IN_BASE = 8'h10;   // channel c lives at 0x10 + c

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_UNMAPPED = 3'd1,
        ERR_RO_WRITE = 3'd2,
        ERR_RANGE    = 3'd3,
        ERR_TIMEOUT  = 3'd4
    } err_code_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DONE  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/a23_gc_byte_ram.sv
// Byte-addressable word RAM for one region: init load on reset, lane-enabled write, aligned read.
// Latency: read combinational (same cycle), write lands on the next clk edge.
// Backpressure: none; every enabled in-range write is accepted, out-of-range accesses are dropped.
module a23_gc_byte_ram
    import a23_gc_pkg::*;
#(
    parameter int WORDS    = 64,
    parameter bit WRITABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORDS*32-1:0]   init,
    input  logic [21:0]           word_addr,
    input  logic                  wr_en,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  in_range,
    output logic [WORDS*32-1:0]   img
);

    localparam int WAW = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Each word holds four byte lanes; lane b is byte address base+b (little-endian)
    logic [3:0][7:0] mem [WORDS];
    logic [WAW-1:0]  widx;

    // The whole word base..base+3 must fit inside the region
    assign in_range = ({10'b0, word_addr} < 32'(WORDS));
    assign widx     = word_addr[WAW-1:0];
    assign rdata    = in_range ? mem[widx] : 32'h0;

    // Reset loads the image (zeros for RAM regions); otherwise apply per-lane writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WORDS; w++) begin
                mem[w] <= init[32*w +: 32];
            end
        end else if (WRITABLE && wr_en && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][b] <= wdata[8*b +: 8];
                end
            end
        end
    end

    for (genvar w = 0; w < WORDS; w++) begin : g_img
        assign img[32*w +: 32] = mem[w];
    end

endmodule

// File: rtl/a23_gc_mem_sys.sv
// a23 GC memory subsystem: code/input/output/stack regions, access checks, run/done/error FSM, cycle counter.
// Latency: reads combinational (same cycle); writes, status and counter update on the next clk edge.
// Backpressure: none; the core is stopped through o_halt once DONE or ERROR is reached.
module a23_gc_mem_sys #(
    parameter int CODE_MEM_SIZE  = 64,
    parameter int NUM_IN_CH      = 2,
    parameter int IN_MEM_SIZE    = 64,
    parameter int OUT_MEM_SIZE   = 64,
    parameter int STACK_MEM_SIZE = 1024,
    parameter int MAX_CYCLES     = 4096,
    parameter int CNT_W          = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CODE_MEM_SIZE*32-1:0]          p_init,
    input  logic [NUM_IN_CH*IN_MEM_SIZE*32-1:0]  in_init,
    input  logic [31:0]                          i_im_address,
    output logic [31:0]                          o_im_read,
    input  logic [31:0]                          i_dm_address,
    input  logic [31:0]                          i_dm_write,
    input  logic                                 i_dm_write_en,
    input  logic [3:0]                           i_dm_byte_enable,
    output logic [31:0]                          o_dm_read,
    output logic [OUT_MEM_SIZE*32-1:0]           o,
    output logic                                 o_halt,
    output logic                                 o_done,
    output logic                                 o_error,
    output logic [2:0]                           o_err_code,
    output logic [CNT_W-1:0]                     o_cycles
);

    import a23_gc_pkg::*;

    localparam bit              TIMEOUT_EN = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] CYC_LIMIT = CNT_W'(MAX_CYCLES - 1);
    localparam int              CAW        = (CODE_MEM_SIZE > 1) ? $clog2(CODE_MEM_SIZE) : 1;

    state_t           state_q, state_d;
    err_code_t        err_q, err_d, acc_err;
    logic [CNT_W-1:0] cyc_q;

    logic [7:0]  dm_pfx;
    logic [21:0] dm_widx;
    logic        run, wr_run;
    logic        sel_out, sel_stack, sel_ctrl, ctrl_done;
    logic        acc_mapped, acc_ro, acc_rng;
    logic [31:0] acc_rd;

    // Byte offsets within a word are implied by the lane enables, not the address
    logic [3:0]  addr_lsb_unused;
    assign addr_lsb_unused = {i_dm_address[1:0], i_im_address[1:0]};

    assign dm_pfx    = i_dm_address[31:24];
    assign dm_widx   = i_dm_address[23:2];
    assign run       = (state_q == ST_RUN);
    assign wr_run    = i_dm_write_en && run;
    assign sel_out   = (dm_pfx == PFX_OUT);
    assign sel_stack = (dm_pfx == PFX_STACK);
    assign sel_ctrl  = (dm_pfx == PFX_CTRL);

    // ---------------- region RAMs ----------------
    logic [31:0]                     code_rd, out_rd, stack_rd;
    logic                            code_rng, out_rng, stack_rng;
    logic [CODE_MEM_SIZE*32-1:0]     code_img;
    logic [STACK_MEM_SIZE*32-1:0]    stack_img_unused;
    logic [31:0]                     in_rd [NUM_IN_CH];
    logic [NUM_IN_CH-1:0]            in_rng;
    logic [IN_MEM_SIZE*32-1:0]       in_img_unused [NUM_IN_CH];

    a23_gc_byte_ram #(.WORDS(CODE_MEM_SIZE), .WRITABLE(1'b0)) u_code (
        .clk       (clk),
        .rst       (rst),
        .init      (p_init),
        .word_addr (dm_widx),
        .wr_en     (1'b0),
        .be        (4'b0000),
        .wdata     (32'h0),
        .rdata     (code_rd),
        .in_range  (code_rng),
        .img       (code_img)
    );

    for (genvar c = 0; c < NUM_IN_CH; c++) begin : g_in
        a23_gc_byte_ram #(.WORDS(IN_MEM_SIZE), .WRITABLE(1'b0)) u_in (
            .clk       (clk),
            .rst       (rst),
            .init      (in_init[c*IN_MEM_SIZE*32 +: IN_MEM_SIZE*32]),
            .word_addr (dm_widx),
            .wr_en     (1'b0),
            .be        (4'b0000),
            .wdata     (32'h0),
            .rdata     (in_rd[c]),
            .in_range  (in_rng[c]),
            .img       (in_img_unused[c])
        );
    end

    a23_gc_byte_ram #(.WORDS(OUT_MEM_SIZE), .WRITABLE(1'b1)) u_out (
        .clk       (clk),
        .rst       (rst),
        .init      ('0),
        .word_addr (dm_widx),
        .wr_en     (wr_run && sel_out),
        .be        (i_dm_byte_enable),
        .wdata     (i_dm_write),
        .rdata     (out_rd),
        .in_range  (out_rng),
        .img       (o)
    );

    a23_gc_byte_ram #(.WORDS(STACK_MEM_SIZE), .WRITABLE(1'b1)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .init      ('0),
        .word_addr (dm_widx),
        .wr_en     (wr_run && sel_stack),
        .be        (i_dm_byte_enable),
        .wdata     (i_dm_write),
        .rdata     (stack_rd),
        .in_range  (stack_rng),
        .img       (stack_img_unused)
    );

    // ---------------- instruction fetch ----------------
    // Prefetch may run past code or into other regions; that returns a NOP, never a fault
    logic           im_hit;
    logic [CAW-1:0] im_idx;
    assign im_hit    = (i_im_address[31:24] == PFX_CODE) &&
                       ({10'b0, i_im_address[23:2]} < 32'(CODE_MEM_SIZE));
    assign im_idx    = i_im_address[CAW+1:2];
    assign o_im_read = im_hit ? code_img[32*im_idx +: 32] : 32'h0;

    // ---------------- data-side decode ----------------
    // Select the addressed region, its read data, and whether it is mapped / read-only / in range
    always_comb begin
        acc_rd     = 32'h0;
        acc_mapped = 1'b0;
        acc_ro     = 1'b0;
        acc_rng    = 1'b0;
        for (int c = 0; c < NUM_IN_CH; c++) begin
            if ((dm_pfx == PFX_IN_BASE + 8'(c)) ||
                (c == 0 && dm_pfx == PFX_IN0) ||
                (c == 1 && dm_pfx == PFX_IN1)) begin
                acc_mapped = 1'b1;
                acc_ro     = 1'b1;
                acc_rng    = in_rng[c];
                acc_rd     = in_rd[c];
            end
        end
        case (dm_pfx)
            PFX_CODE: begin
                acc_mapped = 1'b1;
                acc_ro     = 1'b1;
                acc_rng    = code_rng;
                acc_rd     = code_rd;
            end
            PFX_OUT: begin
                acc_mapped = 1'b1;
                acc_rng    = out_rng;
                acc_rd     = out_rd;
            end
            PFX_STACK: begin
                acc_mapped = 1'b1;
                acc_rng    = stack_rng;
                acc_rd     = stack_rd;
            end
            // Control is a single write-only word; it reads as zero
            PFX_CTRL: begin
                acc_mapped = 1'b1;
                acc_rng    = (dm_widx == 22'd0);
            end
            default: ;
        endcase
    end

    assign o_dm_read = acc_rng ? acc_rd : 32'h0;

    // Classify the current data access; a read-only write outranks a range error on the same access
    always_comb begin
        acc_err = ERR_NONE;
        if (!acc_mapped) begin
            acc_err = ERR_UNMAPPED;
        end else if (i_dm_write_en && acc_ro) begin
            acc_err = ERR_RO_WRITE;
        end else if (!acc_rng) begin
            acc_err = ERR_RANGE;
        end
    end

    // Only a full-word store to the control word ends the run
    assign ctrl_done = sel_ctrl && i_dm_write_en && (i_dm_byte_enable == 4'b1111);

    // ---------------- status FSM ----------------
    // Next state: access fault beats completion, completion beats timeout; DONE/ERROR hold until reset
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (state_q == ST_RUN) begin
            if (acc_err != ERR_NONE) begin
                state_d = ST_ERROR;
                err_d   = acc_err;
            end else if (ctrl_done) begin
                state_d = ST_DONE;
            end else if (TIMEOUT_EN && (cyc_q == CYC_LIMIT)) begin
                state_d = ST_ERROR;
                err_d   = ERR_TIMEOUT;
            end
        end
    end

    // State, error code and cycle counter; the counter stops on the edge that leaves RUN and saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            err_q   <= ERR_NONE;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if ((state_q == ST_RUN) && (state_d == ST_RUN) && (cyc_q != '1)) begin
                cyc_q <= cyc_q + 1'b1;
            end
        end
    end

    assign o_done     = (state_q == ST_DONE);
    assign o_error    = (state_q == ST_ERROR);
    assign o_halt     = o_done || o_error;
    assign o_err_code = err_q;
    assign o_cycles   = cyc_q;

endmodule

// File: tb/tb_a23_gc_mem_sys.sv
// Directed bench for a23_gc_mem_sys: default instance plus a MAX_CYCLES=16 instance for timeout cases.
// Latency: inputs change 1-2 time units after posedge; outputs sampled away from the edge.
// Backpressure: n/a.
module tb_a23_gc_mem_sys;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [64*32-1:0]     p_init;
    logic [2*64*32-1:0]   in_init;
    logic [31:0]          i_im_address, i_dm_address, i_dm_write;
    logic                 i_dm_write_en;
    logic [3:0]           i_dm_byte_enable;

    logic [31:0]          o_im_read, o_dm_read, o_cycles;
    logic [64*32-1:0]     o;
    logic                 o_halt, o_done, o_error;
    logic [2:0]           o_err_code;

    logic [31:0]          t_im_read, t_dm_read, t_cycles;
    logic [64*32-1:0]     t_o;
    logic                 t_halt, t_done, t_error;
    logic [2:0]           t_err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    a23_gc_mem_sys u_dut (
        .clk(clk), .rst(rst), .p_init(p_init), .in_init(in_init),
        .i_im_address(i_im_address), .o_im_read(o_im_read),
        .i_dm_address(i_dm_address), .i_dm_write(i_dm_write),
        .i_dm_write_en(i_dm_write_en), .i_dm_byte_enable(i_dm_byte_enable),
        .o_dm_read(o_dm_read), .o(o), .o_halt(o_halt), .o_done(o_done),
        .o_error(o_error), .o_err_code(o_err_code), .o_cycles(o_cycles)
    );

    a23_gc_mem_sys #(.MAX_CYCLES(16)) u_dut_to (
        .clk(clk), .rst(rst), .p_init(p_init), .in_init(in_init),
        .i_im_address(i_im_address), .o_im_read(t_im_read),
        .i_dm_address(i_dm_address), .i_dm_write(i_dm_write),
        .i_dm_write_en(i_dm_write_en), .i_dm_byte_enable(i_dm_byte_enable),
        .o_dm_read(t_dm_read), .o(t_o), .o_halt(t_halt), .o_done(t_done),
        .o_error(t_error), .o_err_code(t_err_code), .o_cycles(t_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [31:0] addr);
        i_dm_address     = addr;
        i_dm_write       = 32'h0;
        i_dm_write_en    = 1'b0;
        i_dm_byte_enable = 4'b0000;
        #1;
    endtask

    task automatic set_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        i_dm_address     = addr;
        i_dm_write       = data;
        i_dm_write_en    = 1'b1;
        i_dm_byte_enable = be;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_im_address = 32'h0;
        set_rd(32'h0000_0000);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", o_halt); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", o_error); end
        checks++; if (o_err_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", o_err_code); end
        checks++; if (o_cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", o_cycles); end
        checks++; if (o !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", o[63:0]); end
    endtask

    task automatic test_input_read();
        do_reset();
        set_rd(32'h0100_0000);
        checks++; if (o_dm_read !== 32'h11223344) begin errors++; $display("FAIL in0_legacy: got %h want 11223344", o_dm_read); end
        set_rd(32'h1000_0000);
        checks++; if (o_dm_read !== 32'h11223344) begin errors++; $display("FAIL in0_ext: got %h want 11223344", o_dm_read); end
        set_rd(32'h0100_0002);
        checks++; if (o_dm_read !== 32'h11223344) begin errors++; $display("FAIL in0_unaligned: got %h want 11223344", o_dm_read); end
        set_rd(32'h0200_0000);
        checks++; if (o_dm_read !== 32'h55667788) begin errors++; $display("FAIL in1_legacy: got %h want 55667788", o_dm_read); end
        set_rd(32'h1100_0000);
        checks++; if (o_dm_read !== 32'h55667788) begin errors++; $display("FAIL in1_ext: got %h want 55667788", o_dm_read); end
        set_rd(32'h0000_0004);
        checks++; if (o_dm_read !== 32'hDEADBEEF) begin errors++; $display("FAIL code_dm_read: got %h want deadbeef", o_dm_read); end
        i_im_address = 32'h0000_00FC; #1;
        checks++; if (o_im_read !== 32'hCAFEF00D) begin errors++; $display("FAIL fetch_last: got %h want cafef00d", o_im_read); end
        i_im_address = 32'h0000_0100; #1;
        checks++; if (o_im_read !== 32'h0) begin errors++; $display("FAIL fetch_oor: got %h want 0", o_im_read); end
        tick();
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL read_nofault: got %b want 0", o_error); end
        i_im_address = 32'h0;
    endtask

    task automatic test_byte_write();
        do_reset();
        set_wr(32'h0300_0004, 32'hAABBCCDD, 4'b0100);
        tick();
        set_rd(32'h0300_0004);
        checks++; if (o[63:32] !== 32'h00BB0000) begin errors++; $display("FAIL be0100_out: got %h want 00bb0000", o[63:32]); end
        checks++; if (o_dm_read !== 32'h00BB0000) begin errors++; $display("FAIL be0100_rd: got %h want 00bb0000", o_dm_read); end
        set_wr(32'h0300_0000, 32'h12345678, 4'b1001);
        tick();
        checks++; if (o[31:0] !== 32'h12000078) begin errors++; $display("FAIL be1001_out: got %h want 12000078", o[31:0]); end
        set_wr(32'h0300_0008, 32'hFFFFFFFF, 4'b0000);
        tick();
        checks++; if (o[95:64] !== 32'h0) begin errors++; $display("FAIL be0000_noop: got %h want 0", o[95:64]); end
        set_wr(32'h0300_00FC, 32'hCAFEBABE, 4'b1111);
        tick();
        checks++; if (o[2047:2016] !== 32'hCAFEBABE) begin errors++; $display("FAIL out_last: got %h want cafebabe", o[2047:2016]); end
        set_wr(32'h0400_0FFC, 32'hA5A5A5A5, 4'b1111);
        tick();
        set_rd(32'h0400_0FFE);
        checks++; if (o_dm_read !== 32'hA5A5A5A5) begin errors++; $display("FAIL stack_last: got %h want a5a5a5a5", o_dm_read); end
        tick();
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL write_nofault: got %b want 0", o_error); end
    endtask

    task automatic test_access_faults();
        do_reset();
        set_rd(32'h0400_1000);
        checks++; if (o_dm_read !== 32'h0) begin errors++; $display("FAIL oor_read: got %h want 0", o_dm_read); end
        tick();
        checks++; if (o_err_code !== 3'd3 || o_error !== 1'b1) begin errors++; $display("FAIL oor_code: got %0d/%b want 3/1", o_err_code, o_error); end
        do_reset();
        set_rd(32'h1200_0000);
        tick();
        checks++; if (o_err_code !== 3'd1 || o_halt !== 1'b1) begin errors++; $display("FAIL unmapped_ch2: got %0d/%b want 1/1", o_err_code, o_halt); end
        do_reset();
        set_wr(32'h0500_0004, 32'h1, 4'b1111);
        tick();
        checks++; if (o_err_code !== 3'd3 || o_done !== 1'b0) begin errors++; $display("FAIL ctrl_oor: got %0d/done=%b want 3/0", o_err_code, o_done); end
    endtask

    task automatic test_ro_write();
        do_reset();
        tick(); tick(); tick();
        set_wr(32'h0200_0000, 32'hFFFFFFFF, 4'b1111);
        tick();
        checks++; if (o_error !== 1'b1 || o_err_code !== 3'd2) begin errors++; $display("FAIL ro_code: got %b/%0d want 1/2", o_error, o_err_code); end
        set_rd(32'h0200_0000);
        checks++; if (o_dm_read !== 32'h55667788) begin errors++; $display("FAIL ro_unchanged: got %h want 55667788", o_dm_read); end
        set_wr(32'h0400_0000, 32'h12345678, 4'b1111);
        tick();
        set_rd(32'h0400_0000);
        tick(); tick();
        checks++; if (o_dm_read !== 32'h0) begin errors++; $display("FAIL err_stack_wr: got %h want 0", o_dm_read); end
        checks++; if (o_cycles !== 32'd3) begin errors++; $display("FAIL err_cycles: got %0d want 3", o_cycles); end
    endtask

    task automatic test_done();
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        set_wr(32'h0500_0000, 32'h1, 4'b1111);
        tick();
        checks++; if (o_done !== 1'b1 || o_halt !== 1'b1 || o_error !== 1'b0) begin errors++; $display("FAIL done_flags: got d=%b h=%b e=%b want 1 1 0", o_done, o_halt, o_error); end
        checks++; if (o_cycles !== 32'd10) begin errors++; $display("FAIL done_cycles: got %0d want 10", o_cycles); end
        set_wr(32'h0300_0000, 32'h00000001, 4'b1111);
        tick();
        checks++; if (o[31:0] !== 32'h0) begin errors++; $display("FAIL done_wr_suppr: got %h want 0", o[31:0]); end
        checks++; if (o_cycles !== 32'd10) begin errors++; $display("FAIL done_frozen: got %0d want 10", o_cycles); end
    endtask

    task automatic test_timeout();
        do_reset();
        i_im_address = 32'h0F00_0000; #1;
        checks++; if (t_im_read !== 32'h0) begin errors++; $display("FAIL fetch_unmapped: got %h want 0", t_im_read); end
        for (int i = 0; i < 15; i++) tick();
        checks++; if (t_error !== 1'b0 || t_cycles !== 32'd15) begin errors++; $display("FAIL pre_timeout: got e=%b c=%0d want 0 15", t_error, t_cycles); end
        tick();
        checks++; if (t_error !== 1'b1 || t_err_code !== 3'd4) begin errors++; $display("FAIL timeout_code: got %b/%0d want 1/4", t_error, t_err_code); end
        tick(); tick();
        checks++; if (t_cycles !== 32'd15) begin errors++; $display("FAIL timeout_frozen: got %0d want 15", t_cycles); end
        checks++; if (o_error !== 1'b0 || o_cycles !== 32'd18) begin errors++; $display("FAIL long_run: got e=%b c=%0d want 0 18", o_error, o_cycles); end
        i_im_address = 32'h0;
    endtask

    task automatic test_done_beats_timeout();
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        set_wr(32'h0500_0000, 32'h1, 4'b1111);
        tick();
        checks++; if (t_done !== 1'b1 || t_error !== 1'b0 || t_cycles !== 32'd15) begin errors++; $display("FAIL done_vs_timeout: got d=%b e=%b c=%0d want 1 0 15", t_done, t_error, t_cycles); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_wr(32'h0300_0000, 32'hDEADBEEF, 4'b1111);
        tick();
        set_wr(32'h0400_0010, 32'h0BADF00D, 4'b1111);
        tick();
        set_rd(32'h0700_0000);
        tick();
        checks++; if (o_err_code !== 3'd1) begin errors++; $display("FAIL pre_rst_fault: got %0d want 1", o_err_code); end
        in_init[31:0] = 32'h99887766;
        do_reset();
        in_init[31:0] = 32'h01010101;
        checks++; if (o[31:0] !== 32'h0) begin errors++; $display("FAIL rst_out_clr: got %h want 0", o[31:0]); end
        checks++; if (o_halt !== 1'b0 || o_error !== 1'b0 || o_err_code !== 3'd0 || o_cycles !== 32'd0) begin errors++; $display("FAIL rst_status: got h=%b e=%b c=%0d n=%0d want 0 0 0 0", o_halt, o_error, o_err_code, o_cycles); end
        set_rd(32'h0400_0010);
        checks++; if (o_dm_read !== 32'h0) begin errors++; $display("FAIL rst_stack_clr: got %h want 0", o_dm_read); end
        set_rd(32'h0100_0000);
        tick();
        checks++; if (o_dm_read !== 32'h99887766) begin errors++; $display("FAIL rst_reload: got %h want 99887766", o_dm_read); end
    endtask

    initial begin
        p_init = '0;
        p_init[31:0]      = 32'hE3A00001;
        p_init[63:32]     = 32'hDEADBEEF;
        p_init[2047:2016] = 32'hCAFEF00D;
        in_init = '0;
        in_init[31:0]       = 32'h11223344;
        in_init[64*32 +: 32] = 32'h55667788;
        i_im_address = 32'h0;
        set_rd(32'h0);

        test_reset();
        test_input_read();
        test_byte_write();
        test_access_faults();
        test_ro_write();
        test_done();
        test_timeout();
        test_done_beats_timeout();
        test_mid_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
